// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder: one digit per clock, LSD first, registered decimal carry.
// Optional invalid-digit check enabled by defining BCD_CHECK_EN; otherwise err is tied to 0.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state, state_next;

  logic [W-1:0]     a_work;
  logic [W-1:0]     b_work;
  logic [W-1:0]     sum_work;
  logic [W-1:0]     sum_merged;
  logic             carry;
  logic             carry_next;
  logic [IDX_W-1:0] index;
  logic [3:0]       a_digit;
  logic [3:0]       b_digit;
  logic [3:0]       digit;
  logic [4:0]       t;
  logic             accept;
  logic             last_step;

  // Single shared digit-add datapath, steered by the digit index.
  always_comb begin
    a_digit    = a_work[4*int'(index) +: 4];
    b_digit    = b_work[4*int'(index) +: 4];
    t          = {1'b0, a_digit} + {1'b0, b_digit} + {4'b0000, carry};
    digit      = t[3:0];
    carry_next = 1'b0;
    if (t > 5'd9) begin
      // Low nibble of (t + 6); invalid digits take the same path without saturation.
      digit      = t[3:0] + 4'd6;
      carry_next = 1'b1;
    end
    sum_merged = sum_work;
    sum_merged[4*int'(index) +: 4] = digit;
  end

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == ADD) && (index == LAST_IDX);

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ADD;
        end
      end
      ADD: begin
        busy = 1'b1;
        if (index == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Work registers and the visible result; sum/cout move only on the completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_work   <= '0;
      b_work   <= '0;
      sum_work <= '0;
      carry    <= 1'b0;
      index    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
    end else if (accept) begin
      a_work   <= a;
      b_work   <= b;
      sum_work <= '0;
      carry    <= cin;
      index    <= '0;
    end else if (state == ADD) begin
      sum_work <= sum_merged;
      carry    <= carry_next;
      index    <= index + 1'b1;
      if (last_step) begin
        sum  <= sum_merged;
        cout <= carry_next;
      end
    end
  end

`ifdef BCD_CHECK_EN
  logic [DIGITS-1:0] bad_digit;
  logic              err_flag;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
    assign bad_digit[gi] = (a[4*gi +: 4] > 4'd9) || (b[4*gi +: 4] > 4'd9);
  end

  // Flag is captured with the operands and published alongside sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag <= 1'b0;
      err      <= 1'b0;
    end else if (accept) begin
      err_flag <= |bad_digit;
      err      <= 1'b0;
    end else if (last_step) begin
      err <= err_flag;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (DIGITS=4): expectations queued at accept, popped on done.
module tb_bcd_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] exp_q[$];
  logic [15:0] held_sum;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: digit-serial decimal add; returns {err, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mc);
    logic [15:0] s;
    logic        c;
    logic        e;
    logic [4:0]  t;
    s = '0;
    c = mc;
    e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = 5'(ma[4*i +: 4]) + 5'(mb[4*i +: 4]) + 5'(c);
      if (t > 5'd9) begin
        t = t + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[4*i +: 4] = t[3:0];
      if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) e = 1'b1;
    end
`ifndef BCD_CHECK_EN
    e = 1'b0;
`endif
    return {e, c, s};
  endfunction

  // Output monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst) begin
      held_sum = '0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e[15:0]));
        check("cout", 32'(cout), 32'(e[16]));
        check("err", 32'(err), 32'(e[17]));
        $display("result sum=%h cout=%0d err=%0d", sum, cout, err);
      end
      held_sum = sum;
    end
  end

  task automatic run_add(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(ta, tb_v, tc));
    $display("accept a=%h b=%h cin=%0d", ta, tb_v, tc);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = (k == 1);
      check("busy_add", 32'(busy), 32'd1);
      check("done_add", 32'(done), 32'd0);
      check("sum_hold", 32'(sum), 32'(held_sum));
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_done", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    check("done_once", 32'(done), 32'd0);
  endtask

  initial begin
    int done_count;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    run_add(16'h1234, 16'h5678, 1'b0);
    run_add(16'h9999, 16'h0001, 1'b0);
    run_add(16'h9999, 16'h9999, 1'b1);
    run_add(16'h1111, 16'h2222, 1'b0);
    run_add(16'h000F, 16'h000F, 1'b1);

    // Start held high: one accept every 6 cycles.
    @(negedge clk);
    a     = 16'h0005;
    b     = 16'h0005;
    cin   = 1'b0;
    start = 1'b1;
    for (int r = 0; r < 3; r++) exp_q.push_back(model(16'h0005, 16'h0005, 1'b0));
    done_count = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (done) done_count++;
      check("b2b_done_slot", 32'(done), 32'((k % 6) == 4));
    end
    start = 1'b0;
    check("b2b_count", 32'(done_count), 32'd3);

    // Reset in the 2nd ADD cycle: abort, no done.
    @(negedge clk);
    a     = 16'h4321;
    b     = 16'h1111;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    $display("reset abort done");
    run_add(16'h0001, 16'h0001, 1'b0);

    // Invalid digit, then a valid add clears err.
    run_add(16'h00A0, 16'h0000, 1'b0);
    run_add(16'h0123, 16'h0456, 1'b0);
    check("err_cleared", 32'(err), 32'd0);

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
